// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset/NOP constants and the bsig
// branch-select encoding also used by pc_control.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;
   localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

   localparam logic [1:0] BSIG_NONE = 2'b00;
   localparam logic [1:0] BSIG_B    = 2'b01;
   localparam logic [1:0] BSIG_BR   = 2'b10;
   localparam logic [1:0] BSIG_HLT  = 2'b11;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding register that catches a memory response
// arriving while the pipeline is stalled.
module fetch_skid_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        unload_i,
   input  logic        clear_i,
   input  logic [15:0] instr_i,
   input  logic [15:0] pc_i,
   output logic [15:0] instr_o,
   output logic [15:0] pc_o,
   output logic        valid_o
);

   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (clear_i || unload_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         instr_d = instr_i;
         pc_d    = pc_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= 16'h0000;
         pc_q    <= 16'h0000;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/rdy handshake and
// fills IF/ID. Define FETCH_PERF_EN to add fetch_cnt/stall_cnt outputs.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc_next,
   input  logic        halt_req,
   input  logic        stall,
   input  logic        flush,
   output logic [15:0] pc_cur,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic        if_valid,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] fetch_cnt,
   output logic [15:0] stall_cnt
`endif
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  instr_q, instr_d;
   logic [15:0]  ifpc_q, ifpc_d;
   logic         valid_q, valid_d;
   logic         gap_q, gap_d;
   logic         req;
   logic         skid_load, skid_unload, skid_clear;
   logic [15:0]  skid_instr, skid_pc;
   logic         skid_valid;

   fetch_skid_buf u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .instr_i  (imem_data),
      .pc_i     (pc_q),
      .instr_o  (skid_instr),
      .pc_o     (skid_pc),
      .valid_o  (skid_valid)
   );

   // gap_q forces one request-free cycle after reset and after an abandoned
   // request, so the memory sees a clean boundary between transactions.
   assign req = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && !gap_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      ifpc_d      = ifpc_q;
      valid_d     = valid_q;
      gap_d       = 1'b0;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;
      if (flush && (state_q != ST_HALT)) begin
         valid_d    = 1'b0;
         instr_d    = NOP_INSTR;
         pc_d       = pc_next;
         skid_clear = 1'b1;
         gap_d      = req;
         state_d    = ST_REQ;
      end else begin
         case (state_q)
            ST_REQ: begin
               if (req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rdy && stall) begin
                  skid_load = 1'b1;
                  state_d   = ST_HOLD;
               end else if (imem_rdy) begin
                  instr_d = imem_data;
                  ifpc_d  = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_next;
                  state_d = halt_req ? ST_HALT : ST_REQ;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  instr_d     = skid_instr;
                  ifpc_d      = skid_pc;
                  valid_d     = skid_valid;
                  skid_unload = 1'b1;
                  pc_d        = pc_next;
                  state_d     = halt_req ? ST_HALT : ST_REQ;
               end
            end
            default: begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         ifpc_q  <= 16'h0000;
         valid_q <= 1'b0;
         gap_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         valid_q <= valid_d;
         gap_q   <= gap_d;
      end
   end

   assign pc_cur    = pc_q;
   assign imem_req  = req;
   assign imem_addr = pc_q;
   assign if_instr  = instr_q;
   assign if_pc     = ifpc_q;
   assign if_valid  = valid_q;
   assign halted    = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
   logic [15:0] fetch_cnt_q, stall_cnt_q;
   logic        ifid_write;

   assign ifid_write = !flush &&
                       (((state_q == ST_WAIT) && imem_rdy && !stall) ||
                        ((state_q == ST_HOLD) && !stall && skid_valid));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= 16'h0000;
         stall_cnt_q <= 16'h0000;
      end else begin
         if (ifid_write && (fetch_cnt_q != 16'hFFFF))
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (stall && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed reset/fetch/stall/flush/halt
// steps, then a randomized run against a transaction-level memory model.
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc_next;
   logic        halt_req;
   logic        stall;
   logic        flush;
   logic [15:0] pc_cur;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        if_valid;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_cnt;
   logic [15:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_next   (pc_next),
      .halt_req  (halt_req),
      .stall     (stall),
      .flush     (flush),
      .pc_cur    (pc_cur),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_rdy  (imem_rdy),
      .imem_data (imem_data),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .if_valid  (if_valid),
      .halted    (halted)
`ifdef FETCH_PERF_EN
      ,
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock edge; inputs are driven and outputs sampled at the falling edge
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // random-phase memory model and scoreboard state
   typedef struct {
      logic [15:0] pc;
      logic [15:0] data;
   } fetch_t;
   fetch_t      exp_q[$];
   fetch_t      got;
   logic        busy;
   int          rem;
   logic [15:0] req_addr;
   logic [15:0] exp_req_addr;
   logic [15:0] snap_instr, snap_pc;
   logic        snap_valid, stall_prev, quiesce;
   int          n_resp, n_deliv;

   initial begin
      rst_n = 1'b0; pc_next = 16'h0000; halt_req = 1'b0; stall = 1'b0;
      flush = 1'b0; imem_rdy = 1'b1; imem_data = 16'hAAAA;
      @(negedge clk);

      // reset held 2 cycles with rdy high
      cyc(); cyc();
      chk("rst_pc", pc_cur, 16'h0000);
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_valid", {15'd0, if_valid}, 16'd0);
      chk("rst_instr", if_instr, NOP);
      chk("rst_halted", {15'd0, halted}, 16'd0);

      rst_n = 1'b1; imem_rdy = 1'b0; pc_next = 16'h0002;
      cyc();
      chk("rel_req", {15'd0, imem_req}, 16'd1);
      chk("rel_addr", imem_addr, 16'h0000);

      // two back-to-back fetches, rdy one cycle after request
      cyc();
      imem_rdy = 1'b1; imem_data = 16'h1234;
      cyc();
      chk("seq1_instr", if_instr, 16'h1234);
      chk("seq1_pc", if_pc, 16'h0000);
      chk("seq1_valid", {15'd0, if_valid}, 16'd1);
      chk("seq1_pccur", pc_cur, 16'h0002);
      imem_rdy = 1'b0; pc_next = 16'h0004;
      cyc();
      imem_rdy = 1'b1; imem_data = 16'h5678;
      cyc();
      chk("seq2_instr", if_instr, 16'h5678);
      chk("seq2_pc", if_pc, 16'h0002);
      chk("seq2_pccur", pc_cur, 16'h0004);
      imem_rdy = 1'b0; pc_next = 16'h0006;

      // stall 3 cycles as BEEF returns
      cyc();
      stall = 1'b1; imem_rdy = 1'b1; imem_data = 16'hBEEF;
      cyc();
      imem_rdy = 1'b0; imem_data = 16'h0BAD;
      chk("stall1_instr", if_instr, 16'h5678);
      chk("stall1_req", {15'd0, imem_req}, 16'd0);
      chk("stall1_pccur", pc_cur, 16'h0004);
      cyc();
      chk("stall2_instr", if_instr, 16'h5678);
      chk("stall2_req", {15'd0, imem_req}, 16'd0);
      cyc();
      chk("stall3_instr", if_instr, 16'h5678);
      stall = 1'b0;
      cyc();
      chk("unstall_instr", if_instr, 16'hBEEF);
      chk("unstall_pc", if_pc, 16'h0004);
      chk("unstall_req", {15'd0, imem_req}, 16'd1);
      chk("unstall_addr", imem_addr, 16'h0006);

      // flush while waiting on a slow response
      cyc(); cyc();
      flush = 1'b1; pc_next = 16'h0040;
      cyc();
      flush = 1'b0; imem_rdy = 1'b1; imem_data = 16'hDEAD;
      chk("flush_valid", {15'd0, if_valid}, 16'd0);
      chk("flush_instr", if_instr, NOP);
      chk("flush_reqgap", {15'd0, imem_req}, 16'd0);
      cyc();
      imem_rdy = 1'b0;
      chk("flush_valid2", {15'd0, if_valid}, 16'd0);
      chk("flush_req", {15'd0, imem_req}, 16'd1);
      chk("flush_addr", imem_addr, 16'h0040);

      // redirect to 0x0010 then halt on that fetch
      flush = 1'b1; pc_next = 16'h0010;
      cyc();
      flush = 1'b0;
      cyc();
      chk("halt_addr", imem_addr, 16'h0010);
      cyc();
      imem_rdy = 1'b1; imem_data = 16'h7777; halt_req = 1'b1; pc_next = 16'h0012;
      cyc();
      imem_rdy = 1'b0; halt_req = 1'b0;
      chk("halt_instr", if_instr, 16'h7777);
      chk("halt_ifpc", if_pc, 16'h0010);
      chk("halt_valid", {15'd0, if_valid}, 16'd1);
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_pccur", pc_cur, 16'h0012);
      cyc();
      chk("halt_valid_drop", {15'd0, if_valid}, 16'd0);
      for (int i = 0; i < 20; i++) begin
         pc_next = 16'($urandom);
         flush = 1'($urandom);
         imem_rdy = 1'($urandom);
         cyc();
         chk("halt_hold_req", {15'd0, imem_req}, 16'd0);
         chk("halt_hold_pc", pc_cur, 16'h0012);
         chk("halt_hold_flag", {15'd0, halted}, 16'd1);
      end
      flush = 1'b0; imem_rdy = 1'b0;
      rst_n = 1'b0;
      cyc();
      chk("halt_rst_pc", pc_cur, 16'h0000);
      chk("halt_rst_flag", {15'd0, halted}, 16'd0);
      rst_n = 1'b1;
      $display("directed phase done: total=%0d", total);

      // randomized run: sequential PCs, random latency and stalls
      busy = 1'b0; rem = 0; req_addr = 16'h0000; exp_req_addr = 16'h0000;
      n_resp = 0; n_deliv = 0; quiesce = 1'b0;
      for (int c = 0; c < 600; c++) begin
         quiesce = (c >= 540);
         stall = quiesce ? 1'b0 : ($urandom_range(0, 9) < 3);
         if (imem_rdy) begin
            imem_rdy = 1'b0;
            busy = 1'b0;
         end
         if (busy) begin
            chk("rnd_req_held", {15'd0, imem_req}, 16'd1);
            chk("rnd_addr_stable", imem_addr, req_addr);
            rem--;
            if (rem == 0) begin
               imem_rdy = 1'b1;
               imem_data = 16'($urandom);
               exp_q.push_back('{pc: req_addr, data: imem_data});
               n_resp++;
            end
         end else if (imem_req && !quiesce) begin
            chk("rnd_req_addr", imem_addr, exp_req_addr);
            req_addr = imem_addr;
            exp_req_addr = exp_req_addr + 16'd2;
            busy = 1'b1;
            rem = $urandom_range(1, 3);
         end
         pc_next = pc_cur + 16'd2;
         snap_instr = if_instr; snap_pc = if_pc; snap_valid = if_valid;
         stall_prev = stall;
         cyc();
         if (stall_prev) begin
            chk("rnd_stall_instr", if_instr, snap_instr);
            chk("rnd_stall_pc", if_pc, snap_pc);
         end
         if (if_valid && (!snap_valid || (if_pc != snap_pc))) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
               chk("rnd_unexpected_deliv", if_pc, 16'hFFFF);
            end else begin
               got = exp_q.pop_front();
               chk("rnd_deliv_pc", if_pc, got.pc);
               chk("rnd_deliv_instr", if_instr, got.data);
               chk("rnd_deliv_pccur", pc_cur, got.pc + 16'd2);
               $display("fetch pc=%h instr=%h", if_pc, if_instr);
            end
         end
      end
      chk("rnd_drain", 16'(exp_q.size()), 16'd0);
      chk("rnd_count", 16'(n_deliv), 16'(n_resp));

`ifdef FETCH_PERF_EN
      rst_n = 1'b0; stall = 1'b0; imem_rdy = 1'b0;
      cyc();
      chk("perf_rst_fetch", fetch_cnt, 16'd0);
      chk("perf_rst_stall", stall_cnt, 16'd0);
      rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         imem_rdy = 1'b1; imem_data = 16'(i);
         pc_next = pc_cur + 16'd2;
         cyc();
         imem_rdy = 1'b0;
      end
      stall = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      stall = 1'b0;
      cyc();
      chk("perf_fetch", fetch_cnt, 16'd5);
      chk("perf_stall", stall_cnt, 16'd4);
      stall = 1'b1;
      for (int i = 0; i < 65540; i++) cyc();
      chk("perf_stall_sat", stall_cnt, 16'hFFFF);
      cyc();
      chk("perf_stall_sat2", stall_cnt, 16'hFFFF);
      stall = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of pc_control.
- Owns the architectural PC register and drives it to pc_control's PC_in.
- Takes the computed PC_out back as pc_next, fetches from a variable-latency instruction memory over a req/rdy handshake, and fills the IF/ID register.
- Handles stall, flush/redirect and the halt condition (bsig==2'b11 path).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word presented on if_instr when no valid instruction is held.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pc_next  input  16  next PC from pc_control PC_out.
- halt_req  input  1  hlt decoded (bsig==2'b11), sampled with pc_next.
- stall  input  1  hazard unit; hold IF/ID and PC.
- flush  input  1  discard current and in-flight fetch; redirect to pc_next.
- pc_cur  output  16  current PC, feeds pc_control PC_in.
- imem_req  output  1  fetch request.
- imem_addr  output  16  fetch address, equals pc_cur.
- imem_rdy  input  1  memory returns data this cycle.
- imem_data  input  16  instruction word, valid when imem_rdy.
- if_instr  output  16  IF/ID instruction.
- if_pc  output  16  PC of if_instr.
- if_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  stage is halted.

Behaviour:
- Reset (rst_n==0 at clk edge), synchronous:
  - pc_cur=RESET_PC, state=REQ, imem_req=0, if_instr=NOP_INSTR, if_pc=0, if_valid=0, halted=0, skid empty.
  - Reset overrides every other input, including mid-wait and in HALT.
- States: REQ, WAIT, HOLD, HALT.
- REQ: imem_req=1, imem_addr=pc_cur, go to WAIT next cycle.
- WAIT: imem_req held at 1 and address held stable until imem_rdy. Minimum latency is req-to-rdy of 1 cycle, so peak throughput is 1 instruction per 2 cycles.
- imem_rdy in WAIT, no stall, no flush:
  - if_instr<=imem_data, if_pc<=pc_cur, if_valid<=1.
  - pc_cur<=pc_next.
  - If halt_req: go to HALT. Otherwise go to REQ.
- imem_rdy in WAIT with stall:
  - imem_data goes into a 1-entry skid register (with its pc), and the FSM goes to HOLD.
  - IF/ID and pc_cur are unchanged.
- HOLD: imem_req=0. On the first cycle with stall==0:
  - Skid contents move to IF/ID and pc_cur<=pc_next.
  - Go to REQ, or to HALT if halt_req.
- Stall with no imem_rdy: IF/ID frozen, outstanding request continues.
- flush (highest priority after reset, any state except HALT):
  - Any imem_data returned that cycle and any skid contents are discarded.
  - if_valid<=0, if_instr<=NOP_INSTR, pc_cur<=pc_next, go to REQ.
  - flush overrides a simultaneous stall.
- flush arriving in WAIT before rdy: the FSM still goes to REQ. The memory must tolerate request abandonment; req drops for exactly 1 cycle.
- HALT:
  - imem_req=0, pc_cur frozen, halted=1.
  - if_valid<=0 one cycle after entry.
  - pc_next and flush are ignored. Exit only via reset.
- PC arithmetic is 16-bit wrap-around (16'hFFFE+2 -> 16'h0000 is produced by pc_control and accepted as is). No alignment check.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs fetch_cnt[15:0] and stall_cnt[15:0].
  - fetch_cnt increments on each instruction written into IF/ID.
  - stall_cnt increments on every cycle with stall==1 and state!=HALT.
  - Both reset to 0 and saturate at 16'hFFFF.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - FSM state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2, HALT=2'd3).
  - RESET_PC default and NOP_INSTR constant.
  - bsig encoding constants (BSIG_NONE, BSIG_B, BSIG_BR, BSIG_HLT), shared with pc_control.
- One sub-module, fetch_skid_buf: the 1-entry instr+pc holding register with load/unload/clear.

Test Plan:
- Reset: hold rst_n=0 2 cycles with imem_rdy=1 -> pc_cur=0000, imem_req=0, if_valid=0, if_instr=NOP_INSTR. Release -> imem_req=1 next cycle at addr 0000.
- Sequential fetch, pc_next=pc_cur+2, rdy 1 cycle after req with data 16'h1234 then 16'h5678 -> if_instr 1234/if_pc 0000, then 5678/if_pc 0002; pc_cur goes 0000 -> 0002 -> 0004.
- Stall on rdy: stall=1 for 3 cycles when data 16'hBEEF returns -> if_instr unchanged, imem_req=0 in HOLD. Stall drops -> if_instr=BEEF one edge later, no refetch of same address.
- Flush during 3-cycle WAIT with pc_next=0040: the late data at old address is never captured, if_valid=0, next imem_addr=0040.
- Halt: halt_req=1 with rdy at pc 0010 -> instruction captured, then halted=1, imem_req stays 0 for 20 cycles, pc_cur constant. rst_n=0 -> pc_cur=0000, halted=0.
- FETCH_PERF_EN build: 5 fetches plus 4 stall cycles -> fetch_cnt=5, stall_cnt=4. Forced-saturation run holds at FFFF.
